id_ex_operand_stage: RTL and testbench

- Decode-to-execute pipeline register for the 5-stage RV32I core, fused with the execute-stage operand forwarding muxes.
- Latches decoded operands and control from decode.
- Consumes forward_a_t / forward_b_t selects from pkg_hazard_unit, produced by the hazard unit. Drives forwarded src_a and write-data/src_b to the ALU and memory stage.
- Holds forwarded values across execute stalls, so operands are not lost when later stages drain.

---
 rtl/id_ex_operand_stage.sv | 108 ++++++++++
 tb/tb_id_ex_operand_stage.sv | 126 ++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: decode-to-execute pipeline register with execute-stage operand forwarding
// Ports: clk/reset (sync, active-high); stall_e/flush_e from the hazard unit; d_* decoded fields in;
// forward_a/forward_b selects (01 = writeback result, 10 = memory ALU result, 00/11 = register data);
// e_* registered fields out; e_src_a/e_src_b forwarded operands; e_is_load for load-use detection;
// fwd_illegal sticky flag for select 2'b11 on a valid instruction, built only with ID_EX_FWD_CHECK_EN.
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_e,
  input  logic                  flush_e,
  input  logic                  d_valid,
  input  logic [XLEN-1:0]       d_rd1,
  input  logic [XLEN-1:0]       d_rd2,
  input  logic [REG_ADDR_W-1:0] d_rs1,
  input  logic [REG_ADDR_W-1:0] d_rs2,
  input  logic [REG_ADDR_W-1:0] d_rd,
  input  logic [XLEN-1:0]       d_imm,
  input  logic [XLEN-1:0]       d_pc,
  input  logic                  d_reg_write,
  input  logic                  d_mem_write,
  input  logic                  d_branch,
  input  logic                  d_jump,
  input  logic [1:0]            d_result_src,
  input  logic [1:0]            forward_a,
  input  logic [1:0]            forward_b,
  input  logic [XLEN-1:0]       m_alu_result,
  input  logic [XLEN-1:0]       w_result,
  output logic                  e_valid,
  output logic                  e_reg_write,
  output logic                  e_mem_write,
  output logic                  e_branch,
  output logic                  e_jump,
  output logic [1:0]            e_result_src,
  output logic                  e_is_load,
  output logic [REG_ADDR_W-1:0] e_rs1,
  output logic [REG_ADDR_W-1:0] e_rs2,
  output logic [REG_ADDR_W-1:0] e_rd,
  output logic [XLEN-1:0]       e_imm,
  output logic [XLEN-1:0]       e_pc,
  output logic [XLEN-1:0]       e_src_a,
  output logic [XLEN-1:0]       e_src_b,
  output logic                  fwd_illegal
);
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  logic [XLEN-1:0] op_a_q, op_b_q;
  logic bubble;
  assign bubble = reset || flush_e || (!stall_e && !d_valid);
  // x0 never receives forwarded data; 2'b11 falls through to register data
  always_comb begin
    e_src_a = (e_rs1 == '0) ? op_a_q : (forward_a == FWD_WB) ? w_result :
              (forward_a == FWD_MEM) ? m_alu_result : op_a_q;
    e_src_b = (e_rs2 == '0) ? op_b_q : (forward_b == FWD_WB) ? w_result :
              (forward_b == FWD_MEM) ? m_alu_result : op_b_q;
  end
  assign e_is_load = e_valid && (e_result_src == 2'b01);
  always_ff @(posedge clk) begin
    if (bubble) begin
      e_valid      <= 1'b0;
      e_reg_write  <= 1'b0;
      e_mem_write  <= 1'b0;
      e_branch     <= 1'b0;
      e_jump       <= 1'b0;
      e_result_src <= '0;
      e_rs1        <= '0;
      e_rs2        <= '0;
      e_rd         <= '0;
      e_imm        <= '0;
      e_pc         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else if (stall_e) begin
      // freeze whatever is being forwarded now so it survives the producer retiring
      op_a_q <= e_src_a;
      op_b_q <= e_src_b;
    end else begin
      e_valid      <= 1'b1;
      e_reg_write  <= d_reg_write;
      e_mem_write  <= d_mem_write;
      e_branch     <= d_branch;
      e_jump       <= d_jump;
      e_result_src <= d_result_src;
      e_rs1        <= d_rs1;
      e_rs2        <= d_rs2;
      e_rd         <= d_rd;
      e_imm        <= d_imm;
      e_pc         <= d_pc;
      op_a_q       <= d_rd1;
      op_b_q       <= d_rd2;
    end
  end
`ifdef ID_EX_FWD_CHECK_EN
  logic illegal_sel;
  assign illegal_sel = e_valid && (forward_a == 2'b11 || forward_b == 2'b11);
  always_ff @(posedge clk) begin
    if (reset) fwd_illegal <= 1'b0;
    else if (illegal_sel) fwd_illegal <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!reset && illegal_sel) $error("illegal forward select a=%b b=%b", forward_a, forward_b);
  end
`else
  assign fwd_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;
  logic clk = 1'b0;
  logic reset, stall_e, flush_e, d_valid;
  logic [31:0] d_rd1, d_rd2, d_imm, d_pc, m_alu_result, w_result;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic d_reg_write, d_mem_write, d_branch, d_jump;
  logic [1:0] d_result_src, forward_a, forward_b;
  logic e_valid, e_reg_write, e_mem_write, e_branch, e_jump, e_is_load, fwd_illegal;
  logic [1:0] e_result_src;
  logic [4:0] e_rs1, e_rs2, e_rd;
  logic [31:0] e_imm, e_pc, e_src_a, e_src_b;
  int total = 0;
  int bad = 0;
`ifdef ID_EX_FWD_CHECK_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif
  always #5 clk = ~clk;
  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e), .d_valid(d_valid),
    .d_rd1(d_rd1), .d_rd2(d_rd2), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_imm(d_imm), .d_pc(d_pc), .d_reg_write(d_reg_write), .d_mem_write(d_mem_write),
    .d_branch(d_branch), .d_jump(d_jump), .d_result_src(d_result_src),
    .forward_a(forward_a), .forward_b(forward_b), .m_alu_result(m_alu_result),
    .w_result(w_result), .e_valid(e_valid), .e_reg_write(e_reg_write),
    .e_mem_write(e_mem_write), .e_branch(e_branch), .e_jump(e_jump),
    .e_result_src(e_result_src), .e_is_load(e_is_load), .e_rs1(e_rs1), .e_rs2(e_rs2),
    .e_rd(e_rd), .e_imm(e_imm), .e_pc(e_pc), .e_src_a(e_src_a), .e_src_b(e_src_b),
    .fwd_illegal(fwd_illegal)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1; stall_e = 0; flush_e = 0; d_valid = 1;
    d_rd1 = 32'h11; d_rd2 = 32'h44; d_rs1 = 3; d_rs2 = 4; d_rd = 7;
    d_imm = 32'h100; d_pc = 32'h200; d_reg_write = 1; d_mem_write = 0;
    d_branch = 0; d_jump = 0; d_result_src = 2'b01;
    forward_a = 0; forward_b = 0; m_alu_result = 32'h22; w_result = 32'h33;
    step(); step();
    chk("rst_valid", e_valid, 0);
    chk("rst_regw", e_reg_write, 0);
    chk("rst_rd", e_rd, 0);
    chk("rst_src_a", e_src_a, 0);
    chk("rst_src_b", e_src_b, 0);
    chk("rst_load", e_is_load, 0);
    chk("rst_pc", e_pc, 0);
    chk("rst_ill", fwd_illegal, 0);
    reset = 0;
    step();
    chk("ld_valid", e_valid, 1);
    chk("ld_src_a", e_src_a, 32'h11);
    chk("ld_src_b", e_src_b, 32'h44);
    chk("ld_rd", e_rd, 7);
    chk("ld_imm", e_imm, 32'h100);
    chk("ld_pc", e_pc, 32'h200);
    chk("ld_is_load", e_is_load, 1);
    forward_a = 2'b10; #1 chk("fa_mem", e_src_a, 32'h22);
    forward_a = 2'b01; #1 chk("fa_wb", e_src_a, 32'h33);
    forward_a = 2'b11; #1 chk("fa_11", e_src_a, 32'h11);
    forward_a = 2'b00;
    forward_b = 2'b10; #1 chk("fb_mem", e_src_b, 32'h22);
    forward_b = 2'b01; #1 chk("fb_wb", e_src_b, 32'h33);
    forward_b = 2'b11; #1 chk("fb_11", e_src_b, 32'h44);
    forward_b = 2'b00; #1 chk("fb_00", e_src_b, 32'h44);
    d_rs2 = 0; d_rd2 = 0;
    step();
    forward_b = 2'b10; m_alu_result = 32'hDEAD; #1
    chk("x0_mem", e_src_b, 0);
    forward_b = 2'b01; #1 chk("x0_wb", e_src_b, 0);
    forward_a = 2'b10; #1 chk("rs1_mem", e_src_a, 32'hDEAD);
    forward_b = 2'b00;
    m_alu_result = 32'h55; stall_e = 1;
    d_rd1 = 32'hAA; d_rs1 = 5; d_rd = 9; d_pc = 32'h300;
    step();
    forward_a = 2'b00; m_alu_result = 32'h99; #1
    chk("stl_src_a", e_src_a, 32'h55);
    chk("stl_rs1", e_rs1, 3);
    chk("stl_rd", e_rd, 7);
    chk("stl_pc", e_pc, 32'h200);
    chk("stl_valid", e_valid, 1);
    step();
    chk("stl2_src_a", e_src_a, 32'h55);
    stall_e = 0;
    flush_e = 1; stall_e = 1;
    step();
    chk("fl_valid", e_valid, 0);
    chk("fl_regw", e_reg_write, 0);
    chk("fl_rd", e_rd, 0);
    chk("fl_is_load", e_is_load, 0);
    chk("fl_rs1", e_rs1, 0);
    flush_e = 0; stall_e = 0; d_valid = 0;
    step();
    chk("bub_valid", e_valid, 0);
    chk("bub_regw", e_reg_write, 0);
    d_valid = 1;
    step();
    chk("ld2_valid", e_valid, 1);
    chk("ld2_rd", e_rd, 9);
    forward_b = 2'b11;
    step();
    forward_b = 2'b00;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("ill_%0d", i), fwd_illegal, ILL_EXP);
      step();
    end
    stall_e = 1; reset = 1;
    step();
    chk("rs_stl_valid", e_valid, 0);
    chk("rs_stl_rd", e_rd, 0);
    chk("rs_ill", fwd_illegal, 0);
    reset = 0; stall_e = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
